game_key_encoder: RTL and testbench



---
 rtl/game_key_encoder.sv | 166 ++++++++++++++++
 tb/tb_game_key_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_key_encoder.sv
// Maps the 512-bit PS/2 key-state vector onto the 10-bit game key bus with SOCD filtering and press pulses.
// Optional auto-repeat of the most recently pressed key is built when KEY_REPEAT_EN is defined.
module game_key_encoder #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] raw_key_down,
    output logic [9:0]   key_down,
    output logic [9:0]   key_press,
    output logic         any_key,
    output logic         repeat_active,
    output logic [1:0]   dbg_state
);

    // No handshake: every output is a registered level or a one-cycle pulse sampled each clock.
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [9:0] w_mapped;
    logic [9:0] w_filt;
    logic [9:0] w_edge;
    logic [9:0] w_rep_pulse;
    logic [9:0] r_key_down;
    logic [9:0] r_key_press;
    logic       r_any_key;
    logic       w_unused;

    assign w_unused = ^raw_key_down;

    assign w_mapped[0] = raw_key_down[9'h023];
    assign w_mapped[1] = raw_key_down[9'h01D];
    assign w_mapped[2] = raw_key_down[9'h01C];
    assign w_mapped[3] = raw_key_down[9'h01B];
    assign w_mapped[4] = raw_key_down[9'h174];
    assign w_mapped[5] = raw_key_down[9'h175];
    assign w_mapped[6] = raw_key_down[9'h16B];
    assign w_mapped[7] = raw_key_down[9'h172];
    assign w_mapped[8] = raw_key_down[9'h05A];
    assign w_mapped[9] = raw_key_down[9'h076];

    // Opposing directions cancel each other, independently per player.
    assign w_filt[0] = w_mapped[0] & ~w_mapped[2];
    assign w_filt[2] = w_mapped[2] & ~w_mapped[0];
    assign w_filt[1] = w_mapped[1] & ~w_mapped[3];
    assign w_filt[3] = w_mapped[3] & ~w_mapped[1];
    assign w_filt[4] = w_mapped[4] & ~w_mapped[6];
    assign w_filt[6] = w_mapped[6] & ~w_mapped[4];
    assign w_filt[5] = w_mapped[5] & ~w_mapped[7];
    assign w_filt[7] = w_mapped[7] & ~w_mapped[5];
    assign w_filt[9:8] = w_mapped[9:8];

    assign w_edge = w_filt & ~r_key_down;

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_rep_idx;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       w_low_idx;
    logic             w_tracked;

    always_comb begin
        w_low_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_edge[i]) w_low_idx = 4'(i);
        end
    end

    assign w_tracked = w_filt[r_rep_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_rep_idx;
        w_rep_pulse = '0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
            end
            S_DELAY: begin
                if (!w_tracked) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DLY_LAST) begin
                    w_rep_pulse[r_rep_idx] = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!w_tracked) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == PER_LAST) begin
                    w_rep_pulse[r_rep_idx] = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A fresh press always retargets the repeat, even over a pulse emitted this cycle.
        if (|w_edge) begin
            w_idx_nxt   = w_low_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DELAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rep_idx <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rep_idx <= w_idx_nxt;
        end
    end

    assign repeat_active = (r_state == S_REPEAT);
    assign dbg_state     = r_state;
`else
    logic w_unused_params;

    assign w_unused_params = ^{DLY_LAST, PER_LAST};
    assign w_rep_pulse     = '0;
    assign repeat_active   = 1'b0;
    assign dbg_state       = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_down  <= '0;
            r_key_press <= '0;
            r_any_key   <= 1'b0;
        end else begin
            r_key_down  <= w_filt;
            r_key_press <= w_edge | w_rep_pulse;
            r_any_key   <= |w_filt;
        end
    end

    assign key_down  = r_key_down;
    assign key_press = r_key_press;
    assign any_key   = r_any_key;

endmodule

// File: tb/tb_game_key_encoder.sv
// Directed bench for game_key_encoder with REPEAT_DELAY=8, REPEAT_PERIOD=4.
// Repeat scenarios are compiled when KEY_REPEAT_EN is defined, the edge-only scenario otherwise.
module tb_game_key_encoder;

    logic         clk;
    logic         rst_n;
    logic [511:0] raw_key_down;
    logic [9:0]   key_down;
    logic [9:0]   key_press;
    logic         any_key;
    logic         repeat_active;
    logic [1:0]   dbg_state;

    int n_vec;
    int n_err;

    game_key_encoder #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .CNT_W        (25)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_key_down (raw_key_down),
        .key_down     (key_down),
        .key_press    (key_press),
        .any_key      (any_key),
        .repeat_active(repeat_active),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_all();
        raw_key_down = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        raw_key_down = '0;
        raw_key_down[9'h05A] = 1'b1;
        rst_n = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (key_down !== 10'h000 || key_press !== 10'h000 || any_key !== 1'b0 || repeat_active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: down=%h press=%h any=%b rep=%b, want 000 000 0 0",
                     key_down, key_press, any_key, repeat_active);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h100 || key_press !== 10'h100 || any_key !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: down=%h press=%h any=%b, want 100 100 1", key_down, key_press, any_key);
        end
        tick();
        n_vec++;
        if (key_down !== 10'h100 || key_press !== 10'h000) begin
            n_err++;
            $display("FAIL reset_after: down=%h press=%h, want 100 000", key_down, key_press);
        end
        release_all();
    endtask

    task automatic test_mapping();
        raw_key_down[9'h023] = 1'b1;
        raw_key_down[9'h175] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h021 || key_press !== 10'h021 || any_key !== 1'b1) begin
            n_err++;
            $display("FAIL map_press: down=%h press=%h any=%b, want 021 021 1", key_down, key_press, any_key);
        end
        tick();
        n_vec++;
        if (key_down !== 10'h021 || key_press !== 10'h000) begin
            n_err++;
            $display("FAIL map_hold: down=%h press=%h, want 021 000", key_down, key_press);
        end
        raw_key_down = '0;
        raw_key_down[9'h1B] = 1'b1;
        raw_key_down[9'h174] = 1'b1;
        raw_key_down[9'h16B - 9'h000] = 1'b0;
        raw_key_down[9'h076] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h218 || key_press !== 10'h218 || any_key !== 1'b1) begin
            n_err++;
            $display("FAIL map_other: down=%h press=%h any=%b, want 218 218 1", key_down, key_press, any_key);
        end
        raw_key_down = '0;
        tick();
        n_vec++;
        if (key_down !== 10'h000 || key_press !== 10'h000 || any_key !== 1'b0) begin
            n_err++;
            $display("FAIL map_release: down=%h press=%h any=%b, want 000 000 0", key_down, key_press, any_key);
        end
        release_all();
    endtask

    task automatic test_socd();
        raw_key_down[9'h01C] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h004 || key_press !== 10'h004) begin
            n_err++;
            $display("FAIL socd_left: down=%h press=%h, want 004 004", key_down, key_press);
        end
        tick();
        raw_key_down[9'h023] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h000 || key_press !== 10'h000 || any_key !== 1'b0) begin
            n_err++;
            $display("FAIL socd_cancel: down=%h press=%h any=%b, want 000 000 0", key_down, key_press, any_key);
        end
        raw_key_down[9'h01C] = 1'b0;
        tick();
        n_vec++;
        if (key_down !== 10'h001 || key_press !== 10'h001) begin
            n_err++;
            $display("FAIL socd_resume: down=%h press=%h, want 001 001", key_down, key_press);
        end
        raw_key_down = '0;
        tick();
        // P2 up+down cancel, Enter and P1 right unaffected, P2 left survives alone
        raw_key_down[9'h175] = 1'b1;
        raw_key_down[9'h172] = 1'b1;
        raw_key_down[9'h05A] = 1'b1;
        raw_key_down[9'h023] = 1'b1;
        raw_key_down[9'h16B] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h141 || key_press !== 10'h141) begin
            n_err++;
            $display("FAIL socd_p2: down=%h press=%h, want 141 141", key_down, key_press);
        end
        release_all();
    endtask

    task automatic test_back_to_back();
        raw_key_down[9'h023] = 1'b1;
        tick();
        raw_key_down[9'h01D] = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h003 || key_press !== 10'h002) begin
            n_err++;
            $display("FAIL b2b_second: down=%h press=%h, want 003 002", key_down, key_press);
        end
        release_all();
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        logic [9:0] exp_p;
        raw_key_down[9'h175] = 1'b1;
        tick();
        n_vec++;
        if (key_press !== 10'h020 || repeat_active !== 1'b0) begin
            n_err++;
            $display("FAIL rep_t0: press=%h rep=%b, want 020 0", key_press, repeat_active);
        end
        for (int k = 1; k <= 25; k++) begin
            if (k == 20) raw_key_down = '0;
            tick();
            exp_p = (k == 8 || k == 12 || k == 16) ? 10'h020 : 10'h000;
            n_vec++;
            if (key_press !== exp_p || repeat_active !== (k >= 8 && k < 20)) begin
                n_err++;
                $display("FAIL rep_t%0d: press=%h rep=%b, want %h %b",
                         k, key_press, repeat_active, exp_p, (k >= 8 && k < 20));
            end
        end
        release_all();
    endtask

    task automatic test_override();
        logic [9:0] exp_p;
        raw_key_down[9'h01D] = 1'b1;
        tick();
        n_vec++;
        if (key_press !== 10'h002) begin
            n_err++;
            $display("FAIL ovr_t0: press=%h, want 002", key_press);
        end
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) raw_key_down[9'h076] = 1'b1;
            tick();
            exp_p = (k == 5 || k == 13 || k == 17) ? 10'h200 : 10'h000;
            n_vec++;
            if (key_press !== exp_p || repeat_active !== (k >= 13)) begin
                n_err++;
                $display("FAIL ovr_t%0d: press=%h rep=%b, want %h %b", k, key_press, repeat_active, exp_p, (k >= 13));
            end
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        raw_key_down[9'h01D] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (key_down !== 10'h000 || key_press !== 10'h000 || repeat_active !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_in: down=%h press=%h rep=%b, want 000 000 0", key_down, key_press, repeat_active);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (key_down !== 10'h002 || key_press !== 10'h002 || repeat_active !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_out: down=%h press=%h rep=%b, want 002 002 0", key_down, key_press, repeat_active);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (key_press !== ((k == 8) ? 10'h002 : 10'h000)) begin
                n_err++;
                $display("FAIL rstmid_t%0d: press=%h, want %h", k, key_press, (k == 8) ? 10'h002 : 10'h000);
            end
        end
        release_all();
    endtask
`else
    task automatic test_no_repeat();
        int pulses;
        pulses = 0;
        raw_key_down[9'h01D] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (key_press[1]) pulses++;
            n_vec++;
            if (repeat_active !== 1'b0) begin
                n_err++;
                $display("FAIL norep_active_t%0d: rep=%b, want 0", k, repeat_active);
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL norep_pulses: count=%0d, want 1", pulses);
        end
        release_all();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        raw_key_down = '0;
        @(negedge clk);
        test_reset();
        test_mapping();
        test_socd();
        test_back_to_back();
`ifdef KEY_REPEAT_EN
        test_repeat();
        test_override();
        test_reset_mid();
`else
        test_no_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
